// File: rtl/ahb_lite_ctrl_slave.sv
// AHB-Lite register slave for the ASL classifier core: CTRL/ENABLE/STATUS/RESULT,
// read wait states, two-cycle ERROR responses, and start/done handshake with the core.
module ahb_lite_ctrl_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          WAIT_STATES = 1,
  parameter int          RESULT_W    = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ahb_hsel_i,
  input  logic [31:0]         ahb_haddr_i,
  input  logic                ahb_hwrite_i,
  input  logic [2:0]          ahb_hsize_i,
  input  logic [1:0]          ahb_htrans_i,
  input  logic [31:0]         ahb_hwdata_i,
  input  logic                ahb_hready_i,
  output logic                ahb_hreadyout_o,
  output logic                ahb_hresp_o,
  output logic [31:0]         ahb_hrdata_o,
  output logic                core_enable_o,
  output logic                core_start_o,
  input  logic                core_done_i,
  input  logic [RESULT_W-1:0] core_result_i,
  output logic                irq_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_DP   = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_RD_DP   = 3'd3;
  localparam logic [2:0] S_ERR1    = 3'd4;
  localparam logic [2:0] S_ERR2    = 3'd5;

  localparam logic [2:0] WS_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  localparam logic [1:0] R_CTRL   = 2'd0;
  localparam logic [1:0] R_ENABLE = 2'd1;
  localparam logic [1:0] R_STATUS = 2'd2;
  localparam logic [1:0] R_RESULT = 2'd3;

  logic [2:0]          state, state_nx;
  logic [2:0]          wcnt;
  logic [1:0]          sel_q, sel_d, rd_sel;
  logic                map_hit, err_d, acc;
  logic [31:0]         off, rd_val, rdata_q;
  logic                en, irq_en, busy, done, ovr, start_q;
  logic [RESULT_W-1:0] result;
  logic                wr_go, wr_ctrl, wr_enable, wr_status, start_req, start_ok;
  logic                unused_bits;

  assign unused_bits = ^{ahb_hwdata_i[31:3], ahb_htrans_i[0]};

  assign acc = ahb_hsel_i & ahb_hready_i & ahb_htrans_i[1];
  assign off = ahb_haddr_i - ADDR_BASE;

  always_comb begin
    map_hit = 1'b1;
    sel_d   = R_CTRL;
    case (off)
      32'h0000_0000: sel_d = R_CTRL;
      32'h0000_0004: sel_d = R_ENABLE;
      32'h0000_0008: sel_d = R_STATUS;
      32'h0000_2000: sel_d = R_RESULT;
      default:       map_hit = 1'b0;
    endcase
  end

  assign err_d = (ahb_hsize_i != 3'b010) | (ahb_haddr_i[1:0] != 2'b00) | ~map_hit |
                 (ahb_hwrite_i & (sel_d == R_RESULT));

  // Every state that drives HREADYOUT high can accept a pipelined next transfer.
  always_comb begin
    state_nx = state;
    case (state)
      S_RD_WAIT: if (wcnt == 3'd0) state_nx = S_RD_DP;
      S_ERR1:    state_nx = S_ERR2;
      default: begin
        state_nx = S_IDLE;
        if (acc) begin
          if (err_d)                 state_nx = S_ERR1;
          else if (ahb_hwrite_i)     state_nx = S_WR_DP;
          else if (WAIT_STATES == 0) state_nx = S_RD_DP;
          else                       state_nx = S_RD_WAIT;
        end
      end
    endcase
  end

  // Zero-wait reads sample straight from the address phase decode.
  assign rd_sel = (state == S_RD_WAIT) ? sel_q : sel_d;

  always_comb begin
    rd_val = '0;
    case (rd_sel)
      R_CTRL:   rd_val[1]   = irq_en;
      R_ENABLE: rd_val[0]   = en;
      R_STATUS: rd_val[2:0] = {ovr, done, busy};
      default:  rd_val[RESULT_W-1:0] = result;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      wcnt    <= '0;
      sel_q   <= R_CTRL;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (state_nx == S_RD_WAIT && state != S_RD_WAIT) wcnt <= WS_LOAD;
      else if (state == S_RD_WAIT && wcnt != 3'd0)     wcnt <= wcnt - 3'd1;
      if (acc && state != S_RD_WAIT && state != S_ERR1) sel_q <= sel_d;
      if (state_nx == S_RD_DP) rdata_q <= rd_val;
    end
  end

  assign wr_go     = (state == S_WR_DP);
  assign wr_ctrl   = wr_go & (sel_q == R_CTRL);
  assign wr_enable = wr_go & (sel_q == R_ENABLE);
  assign wr_status = wr_go & (sel_q == R_STATUS);
  assign start_req = wr_ctrl & ahb_hwdata_i[0];
  // A done arriving on the same edge frees the core, so the start still goes through.
  assign start_ok  = start_req & en & (~busy | core_done_i);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en      <= 1'b0;
      irq_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovr     <= 1'b0;
      start_q <= 1'b0;
      result  <= '0;
    end else begin
      start_q <= start_ok;
      if (wr_ctrl)   irq_en <= ahb_hwdata_i[1];
      if (wr_enable) en     <= ahb_hwdata_i[0];
      if (start_ok)         busy <= 1'b1;
      else if (core_done_i) busy <= 1'b0;
      if (core_done_i) begin
        done   <= 1'b1;
        result <= core_result_i;
      end else if (wr_status & ahb_hwdata_i[1]) begin
        done <= 1'b0;
      end
      if (start_req & ~start_ok)              ovr <= 1'b1;
      else if (wr_status & ahb_hwdata_i[2])   ovr <= 1'b0;
    end
  end

  assign ahb_hreadyout_o = ~((state == S_RD_WAIT) | (state == S_ERR1));
  assign ahb_hresp_o     = (state == S_ERR1) | (state == S_ERR2);
  assign ahb_hrdata_o    = (state == S_RD_DP) ? rdata_q : 32'h0;
  assign core_enable_o   = en;
  assign core_start_o    = start_q;
  assign irq_o           = done & irq_en;

endmodule

// File: tb/tb_ahb_lite_ctrl_slave.sv
// Bench for ahb_lite_ctrl_slave: vector table, directed corner sequences, and
// randomized accesses checked against a register-level reference model.
module tb_ahb_lite_ctrl_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          WS   = 1;

  logic        clk, resetn;
  logic        hsel, hwrite;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  wire         hready;
  logic        hreadyout, hresp;
  logic [31:0] hrdata;
  logic        en_o, start_o, done_i, irq;
  logic [7:0]  result_i;

  assign hready = hreadyout;

  ahb_lite_ctrl_slave #(.ADDR_BASE(BASE), .WAIT_STATES(WS), .RESULT_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .ahb_hsel_i(hsel), .ahb_haddr_i(haddr), .ahb_hwrite_i(hwrite), .ahb_hsize_i(hsize),
    .ahb_htrans_i(htrans), .ahb_hwdata_i(hwdata), .ahb_hready_i(hready),
    .ahb_hreadyout_o(hreadyout), .ahb_hresp_o(hresp), .ahb_hrdata_o(hrdata),
    .core_enable_o(en_o), .core_start_o(start_o), .core_done_i(done_i),
    .core_result_i(result_i), .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_start = 0;

  always @(posedge clk) if (start_o === 1'b1) n_start <= n_start + 1;

  // reference model state
  logic       m_en, m_irq_en, m_busy, m_done, m_ovr;
  logic [7:0] m_result;
  int         m_starts = 0;

  task automatic m_reset();
    m_en = 0; m_irq_en = 0; m_busy = 0; m_done = 0; m_ovr = 0; m_result = 0;
  endtask

  task automatic m_core_done(input logic [7:0] res);
    m_busy = 0; m_done = 1; m_result = res;
  endtask

  // Expected response/data for one access, then the resulting register state.
  task automatic m_access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] sz, input logic dn, input logic [7:0] dres,
                          output logic e, output logic [31:0] r);
    logic [31:0] off;
    off = a - BASE;
    e = (sz != 3'b010) || (a[1:0] != 2'b00) || !(off inside {32'h0, 32'h4, 32'h8, 32'h2000}) ||
        (wr && off == 32'h2000);
    r = 0;
    if (!e && !wr) begin
      if (off == 32'h0)      r = {30'b0, m_irq_en, 1'b0};
      else if (off == 32'h4) r = {31'b0, m_en};
      else if (off == 32'h8) r = {29'b0, m_ovr, m_done, m_busy};
      else                   r = {24'b0, m_result};
    end
    if (!e && wr && off == 32'h8) begin
      if (wd[1]) m_done = 0;
      if (wd[2]) m_ovr = 0;
    end
    if (!e && wr && off == 32'h4) m_en = wd[0];
    if (!e && wr && off == 32'h0) m_irq_en = wd[1];
    if (dn) m_core_done(dres);
    if (!e && wr && off == 32'h0 && wd[0]) begin
      if (m_en && !m_busy) begin m_busy = 1; m_starts++; end
      else m_ovr = 1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Single non-pipelined transfer; optional core done pulse in the first data-phase cycle.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] sz, input logic dn, input logic [7:0] dres,
                      output logic [31:0] rd, output logic rsp, output int waits, output logic e1);
    hsel = 1; haddr = a; hwrite = wr; hsize = sz; htrans = 2'b10;
    @(posedge clk); #1;
    hsel = 0; htrans = 2'b00; hwdata = wd; done_i = dn; result_i = dres;
    waits = 0; e1 = 0;
    while (!hreadyout && waits < 16) begin
      if (hresp) e1 = 1;
      @(posedge clk); #1;
      done_i = 0;
      waits++;
    end
    rd = hrdata; rsp = hresp;
    @(posedge clk); #1;
    done_i = 0;
  endtask

  task automatic run(input string nm, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] sz, input logic dn, input logic [7:0] dres);
    logic [31:0] rd, er;
    logic        rsp, e1, ee;
    int          w;
    xfer(wr, a, wd, sz, dn, dres, rd, rsp, w, e1);
    m_access(wr, a, wd, sz, dn, dres, ee, er);
    chk({nm, " resp"}, 32'(rsp), 32'(ee));
    chk({nm, " err1"}, 32'(e1), 32'(ee));
    chk({nm, " waits"}, 32'(w), ee ? 32'd1 : (wr ? 32'd0 : 32'(WS)));
    chk({nm, " rdata"}, rd, er);
  endtask

  task automatic pulse_done(input logic [7:0] res);
    done_i = 1; result_i = res;
    @(posedge clk); #1;
    done_i = 0;
    m_core_done(res);
  endtask

  task automatic chk_side(input string nm);
    idle(1);
    chk({nm, " irq"}, 32'(irq), 32'(m_done & m_irq_en));
    chk({nm, " enable"}, 32'(en_o), 32'(m_en));
    chk({nm, " starts"}, 32'(n_start), 32'(m_starts));
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] off;
    logic [31:0] wd;
    logic [2:0]  sz;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  vec_t        tbl[15];
  logic [31:0] offs[7] = '{32'h0, 32'h4, 32'h8, 32'h2000, 32'h100, 32'h6, 32'h3FFC};

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, dummy_r;
    logic        rsp, e1, dummy_e;
    int          w;

    tbl[0]  = '{1'b1, 32'h0,    32'h1, 3'b010, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h4,    32'h0, 3'b010, 1'b0, 32'h0};
    tbl[0].off = 32'h4;
    tbl[2]  = '{1'b1, 32'h0,    32'h2, 3'b010, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 32'h0,    32'h0, 3'b010, 1'b0, 32'h2};
    tbl[4]  = '{1'b0, 32'h8,    32'h0, 3'b010, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 32'h2000, 32'h0, 3'b010, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 32'h100,  32'h0, 3'b010, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 32'h2000, 32'h5, 3'b010, 1'b1, 32'h0};
    tbl[8]  = '{1'b0, 32'h4,    32'h0, 3'b001, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 32'h3FFC, 32'h0, 3'b010, 1'b1, 32'h0};
    tbl[10] = '{1'b1, 32'h0,    32'h0, 3'b010, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 32'h0,    32'h0, 3'b010, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 32'h4,    32'h0, 3'b010, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 32'h6,    32'h1, 3'b010, 1'b1, 32'h0};
    tbl[14] = '{1'b0, 32'h4,    32'h0, 3'b010, 1'b0, 32'h0};
    tbl[1].rd = 32'h1;

    resetn = 0; hsel = 0; haddr = 0; hwrite = 0; hsize = 3'b010; htrans = 0; hwdata = 0;
    done_i = 0; result_i = 0;
    m_reset();
    idle(2);
    chk("rst hreadyout", 32'(hreadyout), 32'd1);
    chk("rst hresp", 32'(hresp), 32'd0);
    chk("rst hrdata", hrdata, 32'd0);
    chk("rst enable", 32'(en_o), 32'd0);
    chk("rst start", 32'(start_o), 32'd0);
    chk("rst irq", 32'(irq), 32'd0);
    resetn = 1;
    idle(1);

    for (int i = 0; i < 15; i++) begin
      xfer(tbl[i].wr, BASE + tbl[i].off, tbl[i].wd, tbl[i].sz, 1'b0, 8'h0, rd, rsp, w, e1);
      m_access(tbl[i].wr, BASE + tbl[i].off, tbl[i].wd, tbl[i].sz, 1'b0, 8'h0, dummy_e, dummy_r);
      chk($sformatf("tbl%0d resp", i), 32'(rsp), 32'(tbl[i].err));
      chk($sformatf("tbl%0d rdata", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d waits", i), 32'(w),
          tbl[i].err ? 32'd1 : (tbl[i].wr ? 32'd0 : 32'(WS)));
    end

    // enable write, zero wait
    chk("t1 pre enable", 32'(en_o), 32'd0);
    run("t1 wr en", 1, BASE + 32'h4, 32'h1, 3'b010, 0, 0);
    chk("t1 enable", 32'(en_o), 32'd1);
    run("t1 rd en", 0, BASE + 32'h4, 0, 3'b010, 0, 0);

    // start pulse, done, result readback
    run("t2 start", 1, BASE, 32'h1, 3'b010, 0, 0);
    chk("t2 start hi", 32'(start_o), 32'd1);
    idle(1);
    chk("t2 start lo", 32'(start_o), 32'd0);
    chk("t2 starts", 32'(n_start), 32'(m_starts));
    run("t2 status busy", 0, BASE + 32'h8, 0, 3'b010, 0, 0);
    pulse_done(8'h17);
    run("t2 status done", 0, BASE + 32'h8, 0, 3'b010, 0, 0);
    run("t2 result", 0, BASE + 32'h2000, 0, 3'b010, 0, 0);

    // error responses leave registers alone
    run("t3 rd unmapped", 0, BASE + 32'h100, 0, 3'b010, 0, 0);
    run("t3 wr misalign", 1, BASE + 32'h6, 32'hFFFF_FFFF, 3'b010, 0, 0);
    run("t3 status", 0, BASE + 32'h8, 0, 3'b010, 0, 0);
    run("t3 enable", 0, BASE + 32'h4, 0, 3'b010, 0, 0);

    // overrun paths
    run("t4 start", 1, BASE, 32'h1, 3'b010, 0, 0);
    run("t4 start busy", 1, BASE, 32'h1, 3'b010, 0, 0);
    chk_side("t4a");
    pulse_done(8'h21);
    run("t4 dis", 1, BASE + 32'h4, 32'h0, 3'b010, 0, 0);
    run("t4 start dis", 1, BASE, 32'h1, 3'b010, 0, 0);
    run("t4 status ovr", 0, BASE + 32'h8, 0, 3'b010, 0, 0);
    run("t4 w1c ovr", 1, BASE + 32'h8, 32'h4, 3'b010, 0, 0);
    run("t4 status", 0, BASE + 32'h8, 0, 3'b010, 0, 0);
    chk_side("t4b");

    // irq and simultaneous events
    run("t5 en", 1, BASE + 32'h4, 32'h1, 3'b010, 0, 0);
    run("t5 start irq", 1, BASE, 32'h3, 3'b010, 0, 0);
    pulse_done(8'h33);
    chk_side("t5a");
    chk("t5 irq set", 32'(irq), 32'd1);
    run("t5 w1c+done", 1, BASE + 32'h8, 32'h2, 3'b010, 1, 8'h44);
    chk("t5 irq held", 32'(irq), 32'd1);
    run("t5 result", 0, BASE + 32'h2000, 0, 3'b010, 0, 0);
    run("t5 start", 1, BASE, 32'h3, 3'b010, 0, 0);
    run("t5 start+done", 1, BASE, 32'h3, 3'b010, 1, 8'h66);
    chk_side("t5b");
    run("t5 status", 0, BASE + 32'h8, 0, 3'b010, 0, 0);
    run("t5 rd+done", 0, BASE + 32'h2000, 0, 3'b010, 1, 8'h55);
    run("t5 rd new", 0, BASE + 32'h2000, 0, 3'b010, 0, 0);
    run("t5 clr done", 1, BASE + 32'h8, 32'h2, 3'b010, 0, 0);
    chk_side("t5c");

    // BUSY/IDLE htrans: zero-wait OKAY
    hsel = 1; haddr = BASE + 32'h100; hwrite = 0; htrans = 2'b01;
    idle(1);
    chk("busy htrans ready", 32'(hreadyout), 32'd1);
    chk("busy htrans resp", 32'(hresp), 32'd0);
    htrans = 2'b00;
    idle(1);
    chk("idle htrans ready", 32'(hreadyout), 32'd1);
    hsel = 0;

    // reset during a read wait state
    hsel = 1; haddr = BASE + 32'h4; hwrite = 0; hsize = 3'b010; htrans = 2'b10;
    idle(1);
    hsel = 0; htrans = 2'b00;
    chk("t6 in wait", 32'(hreadyout), 32'd0);
    resetn = 0;
    #1;
    chk("t6 rst ready", 32'(hreadyout), 32'd1);
    chk("t6 rst resp", 32'(hresp), 32'd0);
    chk("t6 rst rdata", hrdata, 32'd0);
    chk("t6 rst enable", 32'(en_o), 32'd0);
    m_reset();
    idle(2);
    resetn = 1;
    hsel = 1; haddr = BASE + 32'h4; hwrite = 1; htrans = 2'b10;
    idle(1);
    hwdata = 32'h1; hwrite = 0;
    idle(1);
    hsel = 0; htrans = 2'b00;
    chk("t6 b2b wait", 32'(hreadyout), 32'd0);
    idle(1);
    chk("t6 b2b ready", 32'(hreadyout), 32'd1);
    chk("t6 b2b rdata", hrdata, 32'h1);
    chk("t6 b2b resp", 32'(hresp), 32'd0);
    idle(1);
    m_en = 1;
    chk_side("t6");

    for (int i = 0; i < 150; i++) begin
      int k;
      k = int'($urandom_range(0, 11));
      if (k == 0) pulse_done(8'($urandom));
      else run("rand", 1'($urandom_range(0, 1)), BASE + offs[$urandom_range(0, 6)], $urandom,
               ($urandom_range(0, 9) == 0) ? 3'b001 : 3'b010,
               ($urandom_range(0, 7) == 0), 8'($urandom));
      chk_side("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
